// File: rtl/fir_stream_bridge.sv
// Wishbone-to-AXI-Stream bridge for a FIR core: X FIFO feeds the filter input
// stream, Y FIFO collects the filter output stream for register reads.
module fir_stream_bridge #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic              axis_clk,
  input  logic              axis_rst_n,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [7:0]        wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  input  logic [3:0]        wbs_sel_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  output logic              ss_tvalid,
  output logic              ss_tlast,
  output logic [DATA_W-1:0] ss_tdata,
  input  logic              ss_tready,
  input  logic              sm_tvalid,
  input  logic              sm_tlast,
  input  logic [DATA_W-1:0] sm_tdata,
  output logic              sm_tready
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  localparam logic [7:0] ADR_X      = 8'h00;
  localparam logic [7:0] ADR_X_LAST = 8'h04;
  localparam logic [7:0] ADR_Y      = 8'h08;
  localparam logic [7:0] ADR_STATUS = 8'h0C;

  // Byte selects are not honoured: every register access is a full word.
  logic sel_unused;
  assign sel_unused = ^wbs_sel_i;

  generate
    if (DATA_W < 32) begin : g_dat_unused
      logic dat_unused;
      assign dat_unused = ^wbs_dat_i[31:DATA_W];
    end
  endgenerate

  // Storage (no reset; heads are gated by the counts)
  logic [DATA_W:0] x_mem [DEPTH];
  logic [DATA_W:0] y_mem [DEPTH];

  logic [PTR_W-1:0] x_wr_q, x_wr_d, x_rd_q, x_rd_d;
  logic [PTR_W-1:0] y_wr_q, y_wr_d, y_rd_q, y_rd_d;
  logic [CNT_W-1:0] x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d;
  logic             ack_q, ack_d;
  logic [31:0]      dat_q, dat_d;
  logic             ovf_q, ovf_d, udf_q, udf_d, y_last_q, y_last_d;
  logic             rst_done_q;

  logic req;
  logic wr_x, wr_x_last, rd_y, wr_status, rd_status;
  logic x_full, x_empty, y_full, y_empty;
  logic x_push_req, x_push, x_pop, ovf_evt;
  logic y_push, y_pop, udf_evt;
  logic [DATA_W:0] x_head, y_head;
  logic [31:0] status;

  // Bus decode: a request is serviced on the edge that raises ack
  assign req       = wbs_cyc_i & wbs_stb_i & ~ack_q;
  assign wr_x      = req &  wbs_we_i & (wbs_adr_i == ADR_X);
  assign wr_x_last = req &  wbs_we_i & (wbs_adr_i == ADR_X_LAST);
  assign rd_y      = req & ~wbs_we_i & (wbs_adr_i == ADR_Y);
  assign wr_status = req &  wbs_we_i & (wbs_adr_i == ADR_STATUS);
  assign rd_status = req & ~wbs_we_i & (wbs_adr_i == ADR_STATUS);

  assign x_full  = (x_cnt_q == CNT_FULL);
  assign x_empty = (x_cnt_q == '0);
  assign y_full  = (y_cnt_q == CNT_FULL);
  assign y_empty = (y_cnt_q == '0);

  assign x_head = x_mem[x_rd_q];
  assign y_head = y_mem[y_rd_q];

  // Full is judged on the registered count, so a pop on the same edge never
  // makes room for a push.
  assign x_push_req = wr_x | wr_x_last;
  assign x_push     = x_push_req & ~x_full;
  assign ovf_evt    = x_push_req & x_full;
  assign x_pop      = ss_tvalid & ss_tready;

  assign y_push  = sm_tvalid & sm_tready;
  assign y_pop   = rd_y & ~y_empty;
  assign udf_evt = rd_y & y_empty;

  assign ss_tvalid = ~x_empty;
  assign ss_tdata  = x_empty ? '0 : x_head[DATA_W-1:0];
  assign ss_tlast  = ~x_empty & x_head[DATA_W];
  assign sm_tready = rst_done_q & ~y_full;

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;

  assign status = {16'h0000, 4'(y_cnt_q), 4'(x_cnt_q), 1'b0, y_last_q,
                   udf_q, ovf_q, y_empty, y_full, x_empty, x_full};

  always_comb begin
    x_wr_d  = x_wr_q;
    x_rd_d  = x_rd_q;
    x_cnt_d = x_cnt_q;
    if (x_push) x_wr_d = (x_wr_q == PTR_LAST) ? '0 : x_wr_q + PTR_W'(1);
    if (x_pop)  x_rd_d = (x_rd_q == PTR_LAST) ? '0 : x_rd_q + PTR_W'(1);
    case ({x_push, x_pop})
      2'b10:   x_cnt_d = x_cnt_q + CNT_W'(1);
      2'b01:   x_cnt_d = x_cnt_q - CNT_W'(1);
      default: x_cnt_d = x_cnt_q;
    endcase
  end

  always_comb begin
    y_wr_d  = y_wr_q;
    y_rd_d  = y_rd_q;
    y_cnt_d = y_cnt_q;
    if (y_push) y_wr_d = (y_wr_q == PTR_LAST) ? '0 : y_wr_q + PTR_W'(1);
    if (y_pop)  y_rd_d = (y_rd_q == PTR_LAST) ? '0 : y_rd_q + PTR_W'(1);
    case ({y_push, y_pop})
      2'b10:   y_cnt_d = y_cnt_q + CNT_W'(1);
      2'b01:   y_cnt_d = y_cnt_q - CNT_W'(1);
      default: y_cnt_d = y_cnt_q;
    endcase
  end

  // Sticky flags: a set event on the same edge as a W1C write wins
  always_comb begin
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    y_last_d = y_last_q;
    if (wr_status && wbs_dat_i[4]) ovf_d = 1'b0;
    if (wr_status && wbs_dat_i[5]) udf_d = 1'b0;
    if (ovf_evt) ovf_d = 1'b1;
    if (udf_evt) udf_d = 1'b1;
    if (y_pop)   y_last_d = y_head[DATA_W];
  end

  always_comb begin
    ack_d = req;
    dat_d = 32'h0;
    if (y_pop)     dat_d = 32'(y_head[DATA_W-1:0]);
    if (rd_status) dat_d = status;
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      x_wr_q     <= '0;
      x_rd_q     <= '0;
      x_cnt_q    <= '0;
      y_wr_q     <= '0;
      y_rd_q     <= '0;
      y_cnt_q    <= '0;
      ack_q      <= 1'b0;
      dat_q      <= 32'h0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      y_last_q   <= 1'b0;
      rst_done_q <= 1'b0;
    end else begin
      x_wr_q     <= x_wr_d;
      x_rd_q     <= x_rd_d;
      x_cnt_q    <= x_cnt_d;
      y_wr_q     <= y_wr_d;
      y_rd_q     <= y_rd_d;
      y_cnt_q    <= y_cnt_d;
      ack_q      <= ack_d;
      dat_q      <= dat_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
      y_last_q   <= y_last_d;
      rst_done_q <= 1'b1;
    end
  end

  always_ff @(posedge axis_clk) begin
    if (x_push) x_mem[x_wr_q] <= {wr_x_last, wbs_dat_i[DATA_W-1:0]};
    if (y_push) y_mem[y_wr_q] <= {sm_tlast, sm_tdata};
  end

endmodule
